// File: rtl/vga_frame_engine_if.sv
// Read-port pair between the scan engine (master) and the source/processed image memories (slave).
// Addresses are registered by the master; data is expected a fixed number of clocks later.
interface vga_frame_engine_if #(
   parameter int ADDR_W = 19,
   parameter int PIX_W  = 8
) ();
   logic [ADDR_W-1:0] pixel_address_rom;
   logic [ADDR_W-1:0] pixel_address_ram;
   logic [PIX_W-1:0]  pixel_data_rom;
   logic [PIX_W-1:0]  pixel_data_ram;

   modport master (
      output pixel_address_rom,
      output pixel_address_ram,
      input  pixel_data_rom,
      input  pixel_data_ram
   );

   modport slave (
      input  pixel_address_rom,
      input  pixel_address_ram,
      output pixel_data_rom,
      output pixel_data_ram
   );
endinterface

// File: rtl/vga_frame_engine.sv
// Parametrised VGA scan engine: sync timing, ROM/RAM/side-by-side pixel fetch with latency
// compensation, and a push-button display mode that only changes on frame boundaries.
module vga_frame_engine #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int IMG_W    = 256,
   parameter int IMG_H    = 256,
   parameter int ADDR_W   = 19,
   parameter int PIX_W    = 8,
   parameter int MEM_LAT  = 2
) (
   input  logic             clk_25,
   input  logic             rst_n,
   input  logic             enter,
   vga_frame_engine_if.master mem,
   output logic             vga_hsync,
   output logic             vga_vsync,
   output logic             sync_blank,
   output logic             sync_b,
   output logic [PIX_W-1:0] red,
   output logic [PIX_W-1:0] green,
   output logic [PIX_W-1:0] blue,
   output logic             frame_start
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] H_IW   = HW'(IMG_W);
   localparam logic [HW-1:0] H_IW2  = HW'(2 * IMG_W);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_IH   = VW'(IMG_H);

   typedef enum logic [1:0] {SHOW_ROM, SHOW_RAM, SPLIT} mode_e;
   typedef enum logic [1:0] {SEL_NONE, SEL_ROM, SEL_RAM} sel_e;

   typedef struct packed {
      logic hs_n;
      logic vs_n;
      logic vis;
      logic fs;
      sel_e sel;
   } ctl_t;

   localparam ctl_t CTL_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, vis: 1'b0, fs: 1'b0, sel: SEL_NONE};

   logic [HW-1:0]     hcnt_q, hcnt_d;
   logic [VW-1:0]     vcnt_q, vcnt_d;
   logic              btn_meta_q, btn_sync_q, btn_prev_q;
   logic              press, frame_wrap;
   mode_e             mode_q, mode_d, pending_q, pending_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d, ram_addr_q, ram_addr_d;
   logic [ADDR_W-1:0] row_base;
   logic              in_rows, rom_hit, ram_lo_hit, ram_hi_hit;
   ctl_t              ctl_d;
   ctl_t              ctl_q [0:MEM_LAT];
   ctl_t              ctl_last;
   logic [PIX_W-1:0]  pix_q, pix_d;
   logic              hsync_q, vsync_q, blank_q, fs_q;

   function automatic mode_e next_mode(input mode_e m);
      case (m)
         SHOW_ROM: return SHOW_RAM;
         SHOW_RAM: return SPLIT;
         default:  return SHOW_ROM;
      endcase
   endfunction

   always_comb begin
      hcnt_d = hcnt_q + HW'(1);
      vcnt_d = vcnt_q;
      if (hcnt_q == H_LAST) begin
         hcnt_d = '0;
         vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
      end
   end

   assign frame_wrap = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
   assign press      = btn_sync_q & ~btn_prev_q;

   // Mode loads on the edge that wraps into (0,0), so the whole new frame already uses it.
   always_comb begin
      pending_d = pending_q;
      mode_d    = mode_q;
      if (press)
         pending_d = next_mode(pending_q);
      if (frame_wrap)
         mode_d = pending_q;
   end

   always_comb begin
      in_rows    = vcnt_q < V_IH;
      rom_hit    = in_rows && (hcnt_q < H_IW) && (mode_q == SHOW_ROM || mode_q == SPLIT);
      ram_lo_hit = in_rows && (hcnt_q < H_IW) && (mode_q == SHOW_RAM);
      ram_hi_hit = in_rows && (mode_q == SPLIT) && (hcnt_q >= H_IW) && (hcnt_q < H_IW2);
      row_base   = ADDR_W'(vcnt_q) * ADDR_W'(IMG_W);

      rom_addr_d = rom_hit ? row_base + ADDR_W'(hcnt_q) : '0;
      ram_addr_d = '0;
      if (ram_lo_hit)
         ram_addr_d = row_base + ADDR_W'(hcnt_q);
      else if (ram_hi_hit)
         ram_addr_d = row_base + ADDR_W'(hcnt_q - H_IW);

      ctl_d      = CTL_IDLE;
      ctl_d.hs_n = !((hcnt_q >= H_SS) && (hcnt_q < H_SE));
      ctl_d.vs_n = !((vcnt_q >= V_SS) && (vcnt_q < V_SE));
      ctl_d.vis  = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
      ctl_d.fs   = (hcnt_q == '0) && (vcnt_q == '0);
      ctl_d.sel  = rom_hit ? SEL_ROM : ((ram_lo_hit || ram_hi_hit) ? SEL_RAM : SEL_NONE);
   end

   assign ctl_last = ctl_q[MEM_LAT];

   always_comb begin
      pix_d = '0;
      if (ctl_last.vis) begin
         if (ctl_last.sel == SEL_ROM)
            pix_d = mem.pixel_data_rom;
         else if (ctl_last.sel == SEL_RAM)
            pix_d = mem.pixel_data_ram;
      end
   end

   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         hcnt_q     <= '0;
         vcnt_q     <= '0;
         btn_meta_q <= 1'b0;
         btn_sync_q <= 1'b0;
         btn_prev_q <= 1'b0;
         mode_q     <= SHOW_ROM;
         pending_q  <= SHOW_ROM;
         rom_addr_q <= '0;
         ram_addr_q <= '0;
         for (int i = 0; i <= MEM_LAT; i++)
            ctl_q[i] <= CTL_IDLE;
         pix_q      <= '0;
         hsync_q    <= 1'b1;
         vsync_q    <= 1'b1;
         blank_q    <= 1'b0;
         fs_q       <= 1'b0;
      end else begin
         hcnt_q     <= hcnt_d;
         vcnt_q     <= vcnt_d;
         btn_meta_q <= enter;
         btn_sync_q <= btn_meta_q;
         btn_prev_q <= btn_sync_q;
         mode_q     <= mode_d;
         pending_q  <= pending_d;
         rom_addr_q <= rom_addr_d;
         ram_addr_q <= ram_addr_d;
         // Control rides alongside the address, then waits out the memory latency.
         ctl_q[0]   <= ctl_d;
         for (int i = 1; i <= MEM_LAT; i++)
            ctl_q[i] <= ctl_q[i-1];
         pix_q      <= pix_d;
         hsync_q    <= ctl_last.hs_n;
         vsync_q    <= ctl_last.vs_n;
         blank_q    <= ctl_last.vis;
         fs_q       <= ctl_last.fs;
      end
   end

   assign mem.pixel_address_rom = rom_addr_q;
   assign mem.pixel_address_ram = ram_addr_q;
   assign vga_hsync   = hsync_q;
   assign vga_vsync   = vsync_q;
   assign sync_blank  = blank_q;
   assign sync_b      = 1'b0;
   assign red         = pix_q;
   assign green       = pix_q;
   assign blue        = pix_q;
   assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_frame_engine.sv
// Bench for vga_frame_engine: two reduced-size instances with pipelined memory models, a per-cycle
// scoreboard on instance A, table-driven pixel checks, and hand sequences for sync, reset and latency.
module tb_vga_frame_engine;
   localparam int A_HA = 40, A_HF = 4, A_HS = 8, A_HB = 6;
   localparam int A_VA = 20, A_VF = 2, A_VS = 2, A_VB = 3;
   localparam int A_IW = 16, A_IH = 12, A_LAT = 2;
   localparam int A_HT = A_HA + A_HF + A_HS + A_HB;
   localparam int A_VT = A_VA + A_VF + A_VS + A_VB;
   localparam int A_FR = A_HT * A_VT;
   localparam int B_HA = 32, B_HF = 2, B_HS = 4, B_HB = 2;
   localparam int B_VA = 10, B_VF = 1, B_VS = 1, B_VB = 1;
   localparam int B_IW = 8, B_IH = 6, B_LAT = 4;

   logic clk = 1'b0, rst_n = 1'b0, enter_a = 1'b0, enter_b = 1'b0;
   always #5 clk = ~clk;

   logic       hs_a, vs_a, blank_a, syncb_a, fs_a;
   logic [7:0] r_a, g_a, b_a;
   logic       hs_b, vs_b, blank_b, syncb_b, fs_b;
   logic [7:0] r_b, g_b, b_b;

   vga_frame_engine_if #(.ADDR_W(19), .PIX_W(8)) mem_a ();
   vga_frame_engine_if #(.ADDR_W(19), .PIX_W(8)) mem_b ();

   vga_frame_engine #(
      .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
      .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
      .IMG_W(A_IW), .IMG_H(A_IH), .ADDR_W(19), .PIX_W(8), .MEM_LAT(A_LAT)
   ) dut_a (
      .clk_25(clk), .rst_n(rst_n), .enter(enter_a), .mem(mem_a),
      .vga_hsync(hs_a), .vga_vsync(vs_a), .sync_blank(blank_a), .sync_b(syncb_a),
      .red(r_a), .green(g_a), .blue(b_a), .frame_start(fs_a)
   );

   vga_frame_engine #(
      .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
      .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
      .IMG_W(B_IW), .IMG_H(B_IH), .ADDR_W(19), .PIX_W(8), .MEM_LAT(B_LAT)
   ) dut_b (
      .clk_25(clk), .rst_n(rst_n), .enter(enter_b), .mem(mem_b),
      .vga_hsync(hs_b), .vga_vsync(vs_b), .sync_blank(blank_b), .sync_b(syncb_b),
      .red(r_b), .green(g_b), .blue(b_b), .frame_start(fs_b)
   );

   // Memories: ROM returns addr[7:0], RAM returns 0x7F-addr[7:0], each LAT clocks after the address.
   logic [18:0] rom_pa [A_LAT];
   logic [18:0] ram_pa [A_LAT];
   logic [18:0] rom_pb [B_LAT];
   logic [18:0] ram_pb [B_LAT];
   always @(posedge clk) begin
      rom_pa[0] <= mem_a.pixel_address_rom;
      ram_pa[0] <= mem_a.pixel_address_ram;
      for (int i = 1; i < A_LAT; i++) begin
         rom_pa[i] <= rom_pa[i-1];
         ram_pa[i] <= ram_pa[i-1];
      end
      rom_pb[0] <= mem_b.pixel_address_rom;
      ram_pb[0] <= mem_b.pixel_address_ram;
      for (int i = 1; i < B_LAT; i++) begin
         rom_pb[i] <= rom_pb[i-1];
         ram_pb[i] <= ram_pb[i-1];
      end
   end
   assign mem_a.pixel_data_rom = rom_pa[A_LAT-1][7:0];
   assign mem_a.pixel_data_ram = 8'h7F - ram_pa[A_LAT-1][7:0];
   assign mem_b.pixel_data_rom = rom_pb[B_LAT-1][7:0];
   assign mem_b.pixel_data_ram = 8'h7F - ram_pb[B_LAT-1][7:0];

   int vec  = 0;
   int errs = 0;

   task automatic chk(input string name, input int act, input int exp);
      vec++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   typedef struct {
      int h; int v; int mode;
      bit hs; bit vs; bit blank; bit fs;
      int rgb; int arom; int aram;
   } rec_t;

   function automatic rec_t reset_rec();
      rec_t r;
      r.h = -1; r.v = -1; r.mode = -1;
      r.hs = 1'b1; r.vs = 1'b1; r.blank = 1'b0; r.fs = 1'b0;
      r.rgb = 0; r.arom = 0; r.aram = 0;
      return r;
   endfunction

   // Expected behaviour of counter position index j (cycles since reset release) in a given mode.
   function automatic rec_t model_a(input int j, input int mode);
      rec_t r;
      int a;
      r.h = j % A_HT;
      r.v = (j / A_HT) % A_VT;
      r.mode  = mode;
      r.hs    = !(r.h >= A_HA + A_HF && r.h < A_HA + A_HF + A_HS);
      r.vs    = !(r.v >= A_VA + A_VF && r.v < A_VA + A_VF + A_VS);
      r.blank = (r.h < A_HA) && (r.v < A_VA);
      r.fs    = (r.h == 0) && (r.v == 0);
      r.rgb = 0; r.arom = 0; r.aram = 0;
      if (r.v < A_IH) begin
         if (mode != 1 && r.h < A_IW) begin
            r.arom = r.v * A_IW + r.h;
            r.rgb  = r.arom & 255;
         end else if ((mode == 1 && r.h < A_IW) || (mode == 2 && r.h >= A_IW && r.h < 2 * A_IW)) begin
            a = r.v * A_IW + r.h - ((mode == 2) ? A_IW : 0);
            r.aram = a;
            r.rgb  = (127 - a) & 255;
         end
      end
      return r;
   endfunction

   rec_t q_a [$];
   rec_t last_a;
   int   j_a = 0, mode_m = 0, pend_m = 0;
   int   out_h = -1, out_v = -1, out_mode = -1;

   always @(negedge clk) begin
      if (!rst_n) begin
         q_a.delete();
         mode_m = 0; pend_m = 0; j_a = 0;
         out_h = -1; out_v = -1; out_mode = -1;
         for (int i = 0; i < A_LAT + 1; i++) q_a.push_back(reset_rec());
         last_a = model_a(0, 0);
         q_a.push_back(last_a);
      end else begin
         rec_t e;
         j_a++;
         chk("sb_addr_rom", int'(mem_a.pixel_address_rom), last_a.arom);
         chk("sb_addr_ram", int'(mem_a.pixel_address_ram), last_a.aram);
         if (j_a % A_FR == 0) mode_m = pend_m;
         last_a = model_a(j_a, mode_m);
         q_a.push_back(last_a);
         e = q_a.pop_front();
         out_h = e.h; out_v = e.v; out_mode = e.mode;
         chk("sb_hsync", int'(hs_a), int'(e.hs));
         chk("sb_vsync", int'(vs_a), int'(e.vs));
         chk("sb_blank", int'(blank_a), int'(e.blank));
         chk("sb_fs", int'(fs_a), int'(e.fs));
         chk("sb_red", int'(r_a), e.rgb);
         chk("sb_green", int'(g_a), e.rgb);
         chk("sb_blue", int'(b_a), e.rgb);
         chk("sb_sync_b", int'(syncb_a), 0);
      end
   end

   task automatic press_a();
      while ((j_a % A_FR) > A_FR - 40 || (j_a % A_FR) < 5) @(negedge clk);
      enter_a = 1'b1;
      repeat (4) @(negedge clk);
      enter_a = 1'b0;
      repeat (4) @(negedge clk);
      pend_m = (pend_m + 1) % 3;
   endtask

   task automatic press_b();
      enter_b = 1'b1;
      repeat (4) @(negedge clk);
      enter_b = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic fs_latency();
      int fa, fb;
      fa = 0; fb = 0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (fs_a && fa == 0) fa = c;
         if (fs_b && fb == 0) fb = c;
      end
      chk("fs_latency_a", fa, A_LAT + 2);
      chk("fs_latency_b", fb, B_LAT + 2);
   endtask

   function automatic bit sig(input int which);
      case (which)
         0:       return hs_a;
         1:       return vs_a;
         default: return blank_a;
      endcase
   endfunction

   task automatic run_len(input int which, input bit lvl, output int n);
      n = 0;
      while (sig(which) == lvl && n < 4000) begin
         @(negedge clk);
         n++;
      end
   endtask

   typedef struct { int mode; int x; int y; int rgb; bit blank; } vec_t;
   typedef struct { int off; int rgb; bit blank; } bvec_t;

   vec_t  tbl_a [$];
   bvec_t tbl_b [$];
   int    found, n0, n1, cur;

   initial begin
      // Instance A: raster order within each mode; the last entry needs two presses in one frame.
      tbl_a.push_back('{0,  0,  0, 8'h00, 1'b1});
      tbl_a.push_back('{0,  5,  3, 8'h35, 1'b1});
      tbl_a.push_back('{0, 16,  3, 8'h00, 1'b1});
      tbl_a.push_back('{0, 45,  3, 8'h00, 1'b0});
      tbl_a.push_back('{0, 15, 11, 8'hBF, 1'b1});
      tbl_a.push_back('{0,  5, 12, 8'h00, 1'b1});
      tbl_a.push_back('{1,  0,  0, 8'h7F, 1'b1});
      tbl_a.push_back('{1, 20,  2, 8'h00, 1'b1});
      tbl_a.push_back('{1,  5,  3, 8'h4A, 1'b1});
      tbl_a.push_back('{1, 15, 11, 8'hC0, 1'b1});
      tbl_a.push_back('{2,  0,  0, 8'h00, 1'b1});
      tbl_a.push_back('{2, 16,  0, 8'h7F, 1'b1});
      tbl_a.push_back('{2, 15,  2, 8'h2F, 1'b1});
      tbl_a.push_back('{2,  5,  3, 8'h35, 1'b1});
      tbl_a.push_back('{2, 21,  3, 8'h4A, 1'b1});
      tbl_a.push_back('{2, 32,  3, 8'h00, 1'b1});
      tbl_a.push_back('{2, 31, 11, 8'hC0, 1'b1});
      tbl_a.push_back('{0,  5,  3, 8'h35, 1'b1});
      tbl_a.push_back('{2, 16,  0, 8'h7F, 1'b1});
      // Instance B in SPLIT: offsets in clocks after its frame_start.
      tbl_b.push_back('{ 0, 8'h00, 1'b1});
      tbl_b.push_back('{ 7, 8'h07, 1'b1});
      tbl_b.push_back('{ 8, 8'h7F, 1'b1});
      tbl_b.push_back('{ 9, 8'h7E, 1'b1});
      tbl_b.push_back('{15, 8'h78, 1'b1});
      tbl_b.push_back('{16, 8'h00, 1'b1});
      tbl_b.push_back('{32, 8'h00, 1'b0});
      tbl_b.push_back('{47, 8'h0F, 1'b1});
      tbl_b.push_back('{48, 8'h77, 1'b1});
      tbl_b.push_back('{55, 8'h70, 1'b1});

      repeat (3) @(negedge clk);
      chk("rst_hsync", int'(hs_a), 1);
      chk("rst_vsync", int'(vs_a), 1);
      chk("rst_blank", int'(blank_a), 0);
      chk("rst_rgb", int'(r_a), 0);
      #2 rst_n = 1'b1;
      fs_latency();

      // Instance B: two presses in its first frame select SPLIT from the next frame.
      press_b();
      press_b();
      found = 0;
      for (int c = 0; c < 1200 && found == 0; c++) begin
         @(posedge clk); #1;
         if (fs_b) found = 1;
      end
      chk("b_frame_found", found, 1);
      cur = 0;
      for (int k = 0; k < tbl_b.size(); k++) begin
         repeat (tbl_b[k].off - cur) @(posedge clk);
         #1;
         cur = tbl_b[k].off;
         chk($sformatf("b_rgb_x%0d", tbl_b[k].off), int'(r_b), tbl_b[k].rgb);
         chk($sformatf("b_blank_x%0d", tbl_b[k].off), int'(blank_b), int'(tbl_b[k].blank));
      end
      chk("b_sync_b", int'(syncb_b), 0);

      for (int k = 0; k < tbl_a.size(); k++) begin
         while (pend_m != tbl_a[k].mode) press_a();
         found = 0;
         for (int g = 0; g < 4 * A_FR && found == 0; g++) begin
            @(negedge clk); #1;
            if (out_mode == tbl_a[k].mode && out_h == tbl_a[k].x && out_v == tbl_a[k].y) found = 1;
         end
         chk($sformatf("a_found_m%0d_%0d_%0d", tbl_a[k].mode, tbl_a[k].x, tbl_a[k].y), found, 1);
         if (found == 1) begin
            chk($sformatf("a_rgb_m%0d_%0d_%0d", tbl_a[k].mode, tbl_a[k].x, tbl_a[k].y), int'(r_a), tbl_a[k].rgb);
            chk($sformatf("a_blank_m%0d_%0d_%0d", tbl_a[k].mode, tbl_a[k].x, tbl_a[k].y), int'(blank_a), int'(tbl_a[k].blank));
         end
      end

      run_len(0, 1'b0, n0); run_len(0, 1'b1, n0);
      run_len(0, 1'b0, n0); run_len(0, 1'b1, n1);
      chk("hsync_low", n0, A_HS);
      chk("hsync_period", n0 + n1, A_HT);
      run_len(2, 1'b1, n0); run_len(2, 1'b0, n0);
      run_len(2, 1'b1, n1);
      chk("blank_high", n1, A_HA);
      run_len(1, 1'b0, n0); run_len(1, 1'b1, n0);
      run_len(1, 1'b0, n0); run_len(1, 1'b1, n1);
      chk("vsync_low", n0, A_VS * A_HT);
      chk("vsync_period", n0 + n1, A_FR);

      // Mid-frame reset while instance A is drawing visible pixels.
      found = 0;
      for (int g = 0; g < 2 * A_FR && found == 0; g++) begin
         @(negedge clk); #1;
         if (j_a % A_HT == 10 && (j_a / A_HT) % A_VT == 5) found = 1;
      end
      chk("reset_point_found", found, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_hsync", int'(hs_a), 1);
      chk("async_vsync", int'(vs_a), 1);
      chk("async_blank", int'(blank_a), 0);
      chk("async_rgb", int'(r_a), 0);
      chk("async_fs", int'(fs_a), 0);
      chk("async_addr_rom", int'(mem_a.pixel_address_rom), 0);
      chk("async_addr_ram", int'(mem_a.pixel_address_ram), 0);
      chk("async_blank_b", int'(blank_b), 0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      fs_latency();
      repeat (200) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not complete, expected completion before %0t", $time);
      $fatal(1);
   end
endmodule
